rgb_cycle_monitor: RTL and testbench

RGB_CYCLE_MONITOR -- requirements
Module: rgb_cycle_monitor

---
 rtl/rgb_pkg.sv | 62 ++++++
 rtl/sync_2ff.sv | 35 +++
 rtl/rgb_cycle_monitor.sv | 196 +++++++++++++++++++
 tb/tb_rgb_cycle_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB colour-cycle monitor:
//   - color_e      : decoded colour index (RED..MAGENTA = 0..5, NONE = 7)
//   - CODE_*       : active-low {R,G,B} drive patterns (0 = LED lit)
//   - decode_rgb   : maps a synchronised {R,G,B} sample to color_e
//   - next_color   : expected successor in the fade cycle (MAGENTA wraps to RED)
// -----------------------------------------------------------------------------
package rgb_pkg;

  typedef enum logic [2:0] {
    COLOR_RED     = 3'd0,
    COLOR_YELLOW  = 3'd1,
    COLOR_GREEN   = 3'd2,
    COLOR_CYAN    = 3'd3,
    COLOR_BLUE    = 3'd4,
    COLOR_MAGENTA = 3'd5,
    COLOR_NONE    = 3'd7
  } color_e;

  // Active-low {R,G,B} patterns
  localparam logic [2:0] CODE_RED     = 3'b011;
  localparam logic [2:0] CODE_YELLOW  = 3'b001;
  localparam logic [2:0] CODE_GREEN   = 3'b101;
  localparam logic [2:0] CODE_CYAN    = 3'b100;
  localparam logic [2:0] CODE_BLUE    = 3'b110;
  localparam logic [2:0] CODE_MAGENTA = 3'b010;
  localparam logic [2:0] CODE_DARK    = 3'b111;
  localparam logic [2:0] CODE_WHITE   = 3'b000;

  function automatic color_e decode_rgb(input logic [2:0] rgb);
    color_e c;
    case (rgb)
      CODE_RED:     c = COLOR_RED;
      CODE_YELLOW:  c = COLOR_YELLOW;
      CODE_GREEN:   c = COLOR_GREEN;
      CODE_CYAN:    c = COLOR_CYAN;
      CODE_BLUE:    c = COLOR_BLUE;
      CODE_MAGENTA: c = COLOR_MAGENTA;
      CODE_DARK:    c = COLOR_NONE;
      CODE_WHITE:   c = COLOR_NONE;
      default:      c = COLOR_NONE;
    endcase
    return c;
  endfunction

  // NONE has no successor; it maps to NONE so it never matches a real colour.
  function automatic color_e next_color(input logic [2:0] cur);
    color_e c;
    case (cur)
      COLOR_RED:     c = COLOR_YELLOW;
      COLOR_YELLOW:  c = COLOR_GREEN;
      COLOR_GREEN:   c = COLOR_CYAN;
      COLOR_CYAN:    c = COLOR_BLUE;
      COLOR_BLUE:    c = COLOR_MAGENTA;
      COLOR_MAGENTA: c = COLOR_RED;
      default:       c = COLOR_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages load RST_VAL
//   d_i   : asynchronous input bus (WIDTH bits)
//   q_o   : synchronised output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rgb_cycle_monitor.sv
// -----------------------------------------------------------------------------
// rgb_cycle_monitor
// Watches an active-low RGB LED drive cycling RED>YELLOW>GREEN>CYAN>BLUE>
// MAGENTA>RED, measures how long each colour is held and flags sequence and
// dwell-time violations.
//   clk, rst_n      : clock, asynchronous active-low reset
//   RGB_R/G/B       : asynchronous active-low LED drive (0 = lit)
//   clear_err       : synchronous pulse clearing sticky flags and err_count
//   color_idx       : decoded colour (NONE = 7), 3 cycles after the input
//   color_change    : one-cycle pulse on the cycle color_idx takes a new value
//   dwell_cnt       : cycles the current colour has been held (saturating)
//   locked          : FSM is in TRACK
//   seq_err         : sticky, wrong successor or drop to NONE while tracking
//   dwell_err       : sticky, dwell outside FADE_INTERVAL +/- TOLERANCE or stall
//   err_count       : saturating count of error events
// All next-state logic looks at the value about to be loaded into color_idx,
// so flags, state and the new colour all appear on the same cycle.
// -----------------------------------------------------------------------------
module rgb_cycle_monitor
  import rgb_pkg::*;
#(
  parameter int FADE_INTERVAL = 2000000,
  parameter int TOLERANCE     = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         RGB_R,
  input  logic                                         RGB_G,
  input  logic                                         RGB_B,
  input  logic                                         clear_err,
  output logic [2:0]                                   color_idx,
  output logic                                         color_change,
  output logic [$clog2(FADE_INTERVAL+TOLERANCE+2)-1:0] dwell_cnt,
  output logic                                         locked,
  output logic                                         seq_err,
  output logic                                         dwell_err,
  output logic [7:0]                                   err_count
);

  localparam int CW = $clog2(FADE_INTERVAL + TOLERANCE + 2);
  localparam logic [CW-1:0] DWELL_MIN   = CW'(FADE_INTERVAL - TOLERANCE);
  localparam logic [CW-1:0] DWELL_MAX   = CW'(FADE_INTERVAL + TOLERANCE);
  localparam logic [CW-1:0] DWELL_STALL = CW'(FADE_INTERVAL + TOLERANCE + 1);
  localparam logic [CW-1:0] DWELL_SAT   = {CW{1'b1}};

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;

  logic [2:0]    rgb_sync_s;
  logic [2:0]    dec_color_s;
  logic [2:0]    succ_color_s;
  logic          seq_hit_s;
  logic          dwell_hit_s;
  logic          dwell_bad_s;
  logic          err_evt_s;

  logic [2:0]    color_idx_q,    color_idx_d;
  logic          color_change_q, color_change_d;
  logic [CW-1:0] dwell_cnt_q,    dwell_cnt_d;
  logic [1:0]    state_q,        state_d;
  logic          locked_q,       locked_d;
  logic          seq_err_q,      seq_err_d;
  logic          dwell_err_q,    dwell_err_d;
  logic [7:0]    err_count_q,    err_count_d;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b111)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({RGB_R, RGB_G, RGB_B}),
    .q_o   (rgb_sync_s)
  );

  // Colour decode, change detect and dwell counter next values
  always_comb begin
    dec_color_s    = decode_rgb(rgb_sync_s);
    succ_color_s   = next_color(color_idx_q);
    color_idx_d    = dec_color_s;
    color_change_d = (dec_color_s != color_idx_q);
    if (color_change_d) begin
      dwell_cnt_d = CW'(1);
    end else if (dwell_cnt_q == DWELL_SAT) begin
      dwell_cnt_d = dwell_cnt_q;
    end else begin
      dwell_cnt_d = dwell_cnt_q + CW'(1);
    end
  end

  // Lock FSM; dwell_cnt_q still holds the finished colour's dwell on a change
  always_comb begin
    state_d     = state_q;
    seq_hit_s   = 1'b0;
    dwell_hit_s = 1'b0;
    dwell_bad_s = (dwell_cnt_q < DWELL_MIN) || (dwell_cnt_q > DWELL_MAX);
    case (state_q)
      ST_SEARCH: begin
        if (dec_color_s != COLOR_NONE) begin
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_ALIGN: begin
        if (!color_change_d) begin
          state_d = ST_ALIGN;
        end else if (dec_color_s == COLOR_NONE) begin
          state_d = ST_SEARCH;
        end else if (dec_color_s == succ_color_s) begin
          state_d = ST_TRACK;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_TRACK: begin
        if (color_change_d) begin
          dwell_hit_s = dwell_bad_s;
          // A sequence fault decides the next state even if dwell also failed
          if (dec_color_s == COLOR_NONE) begin
            seq_hit_s = 1'b1;
            state_d   = ST_SEARCH;
          end else if (dec_color_s != succ_color_s) begin
            seq_hit_s = 1'b1;
            state_d   = ST_ALIGN;
          end else if (dwell_bad_s) begin
            state_d = ST_ALIGN;
          end else begin
            state_d = ST_TRACK;
          end
        end else if (dwell_cnt_d == DWELL_STALL) begin
          // Leaving TRACK guarantees the stall is reported only once
          dwell_hit_s = 1'b1;
          state_d     = ST_ALIGN;
        end else begin
          state_d = ST_TRACK;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Sticky error flags and error counter; a same-cycle error beats clear_err
  always_comb begin
    err_evt_s = seq_hit_s | dwell_hit_s;
    locked_d  = (state_d == ST_TRACK);
    if (clear_err) begin
      seq_err_d   = seq_hit_s;
      dwell_err_d = dwell_hit_s;
      err_count_d = err_evt_s ? 8'd1 : 8'd0;
    end else begin
      seq_err_d   = seq_err_q | seq_hit_s;
      dwell_err_d = dwell_err_q | dwell_hit_s;
      if (err_evt_s && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_idx_q    <= COLOR_NONE;
      color_change_q <= 1'b0;
      dwell_cnt_q    <= '0;
      state_q        <= ST_SEARCH;
      locked_q       <= 1'b0;
      seq_err_q      <= 1'b0;
      dwell_err_q    <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      color_idx_q    <= color_idx_d;
      color_change_q <= color_change_d;
      dwell_cnt_q    <= dwell_cnt_d;
      state_q        <= state_d;
      locked_q       <= locked_d;
      seq_err_q      <= seq_err_d;
      dwell_err_q    <= dwell_err_d;
      err_count_q    <= err_count_d;
    end
  end

  assign color_idx    = color_idx_q;
  assign color_change = color_change_q;
  assign dwell_cnt    = dwell_cnt_q;
  assign locked       = locked_q;
  assign seq_err      = seq_err_q;
  assign dwell_err    = dwell_err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_rgb_cycle_monitor.sv
// -----------------------------------------------------------------------------
// tb_rgb_cycle_monitor
// Drives colour segments (pattern, hold length, optional clear_err pulse) into
// rgb_cycle_monitor with FADE_INTERVAL=8, TOLERANCE=1. For each segment the
// expected outputs on the last cycle of the previous colour and on the change
// cycle are computed from a segment-level model and queued; a negedge monitor
// pops and compares them when they fall due.
// -----------------------------------------------------------------------------
module tb_rgb_cycle_monitor;

  localparam int FI  = 8;
  localparam int TOL = 1;
  localparam int ST_SEARCH = 0;
  localparam int ST_ALIGN  = 1;
  localparam int ST_TRACK  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RGB_R = 1'b1;
  logic       RGB_G = 1'b1;
  logic       RGB_B = 1'b1;
  logic       clear_err = 1'b0;
  logic [2:0] color_idx;
  logic       color_change;
  logic [3:0] dwell_cnt;
  logic       locked;
  logic       seq_err;
  logic       dwell_err;
  logic [7:0] err_count;

  rgb_cycle_monitor #(
    .FADE_INTERVAL (FI),
    .TOLERANCE     (TOL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RGB_R        (RGB_R),
    .RGB_G        (RGB_G),
    .RGB_B        (RGB_B),
    .clear_err    (clear_err),
    .color_idx    (color_idx),
    .color_change (color_change),
    .dwell_cnt    (dwell_cnt),
    .locked       (locked),
    .seq_err      (seq_err),
    .dwell_err    (dwell_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         seg;
    logic [2:0] color;
    logic       chg;
    logic       chk_dwell;
    logic [3:0] dwell;
    logic       locked;
    logic       seq;
    logic       dwl;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  // Segment-level model state
  int m_state = ST_SEARCH;
  int m_color = 7;
  int m_cnt   = 0;
  bit m_seq   = 1'b0;
  bit m_dwl   = 1'b0;
  int prev_n  = 0;
  int seg_no  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int succ(input int c);
    return (c == 5) ? 0 : c + 1;
  endfunction

  function automatic exp_t snap(input int due, input bit chg, input bit chk_dwell, input int dwell);
    exp_t e;
    e.due       = due;
    e.seg       = seg_no;
    e.color     = 3'(m_color);
    e.chg       = chg;
    e.chk_dwell = chk_dwell;
    e.dwell     = (dwell > 15) ? 4'd15 : 4'(dwell);
    e.locked    = (m_state == ST_TRACK);
    e.seq       = m_seq;
    e.dwl       = m_dwl;
    e.cnt       = 8'(m_cnt);
    return e;
  endfunction

  // Hold one colour pattern for n cycles; clr pulses clear_err on the change cycle
  task automatic run_seg(input logic [2:0] code, input int col, input int n, input bit clr);
    int k;
    bit seq;
    bit dwl;
    k = cyc;
    seg_no++;
    // stall during the previous colour (dwell reached FI+TOL+1 while tracking)
    if (m_state == ST_TRACK && prev_n >= FI + TOL + 1) begin
      m_dwl = 1'b1;
      if (m_cnt < 255) m_cnt++;
      m_state = ST_ALIGN;
    end
    // two cycles after the input change the old colour is still shown
    sb_q.push_back(snap(k + 2, 1'b0, prev_n > 0, prev_n));
    seq = 1'b0;
    dwl = 1'b0;
    case (m_state)
      ST_SEARCH: if (col != 7) m_state = ST_ALIGN;
      ST_ALIGN: begin
        if (col == 7) m_state = ST_SEARCH;
        else if (col == succ(m_color)) m_state = ST_TRACK;
      end
      default: begin
        dwl = (prev_n < FI - TOL) || (prev_n > FI + TOL);
        if (dwl) m_state = ST_ALIGN;
        if (col == 7) begin
          seq = 1'b1;
          m_state = ST_SEARCH;
        end else if (col != succ(m_color)) begin
          seq = 1'b1;
          m_state = ST_ALIGN;
        end
      end
    endcase
    if (clr) begin
      m_seq = seq;
      m_dwl = dwl;
      m_cnt = (seq || dwl) ? 1 : 0;
    end else begin
      m_seq = m_seq | seq;
      m_dwl = m_dwl | dwl;
      if ((seq || dwl) && m_cnt < 255) m_cnt++;
    end
    m_color = col;
    sb_q.push_back(snap(k + 3, 1'b1, 1'b1, 1));
    prev_n = n;
    {RGB_R, RGB_G, RGB_B} = code;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      clear_err = (i == 2) ? clr : 1'b0;
    end
  endtask

  // Assert reset, check outputs immediately, release after two cycles
  task automatic do_reset();
    rst_n = 1'b0;
    {RGB_R, RGB_G, RGB_B} = 3'b111;
    clear_err = 1'b0;
    #1;
    chk_eq("rst_color_idx", color_idx, 32'd7);
    chk_eq("rst_color_change", color_change, 32'd0);
    chk_eq("rst_dwell_cnt", dwell_cnt, 32'd0);
    chk_eq("rst_locked", locked, 32'd0);
    chk_eq("rst_seq_err", seq_err, 32'd0);
    chk_eq("rst_dwell_err", dwell_err, 32'd0);
    chk_eq("rst_err_count", err_count, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_state = ST_SEARCH;
    m_color = 7;
    m_cnt   = 0;
    m_seq   = 1'b0;
    m_dwl   = 1'b0;
    prev_n  = 0;
  endtask

  // Scoreboard: compare queued expectations when they fall due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due != cyc) begin
          chk_eq($sformatf("seg%0d_sched", e.seg), cyc, e.due);
        end else begin
          chk_eq($sformatf("seg%0d_c%0d_color_idx", e.seg, e.chg), color_idx, e.color);
          chk_eq($sformatf("seg%0d_c%0d_color_change", e.seg, e.chg), color_change, e.chg);
          if (e.chk_dwell) chk_eq($sformatf("seg%0d_c%0d_dwell_cnt", e.seg, e.chg), dwell_cnt, e.dwell);
          chk_eq($sformatf("seg%0d_c%0d_locked", e.seg, e.chg), locked, e.locked);
          chk_eq($sformatf("seg%0d_c%0d_seq_err", e.seg, e.chg), seq_err, e.seq);
          chk_eq($sformatf("seg%0d_c%0d_dwell_err", e.seg, e.chg), dwell_err, e.dwl);
          chk_eq($sformatf("seg%0d_c%0d_err_count", e.seg, e.chg), err_count, e.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    // clean cycle, including 7 and 9 cycle dwells and the MAGENTA>RED wrap
    run_seg(3'b011, 0, 8, 1'b0);
    run_seg(3'b001, 1, 8, 1'b0);
    run_seg(3'b101, 2, 8, 1'b0);
    run_seg(3'b100, 3, 7, 1'b0);
    run_seg(3'b110, 4, 9, 1'b0);
    run_seg(3'b010, 5, 8, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    run_seg(3'b001, 1, 8, 1'b0);
    // short GREEN then jump to BLUE: seq and dwell error together
    run_seg(3'b101, 2, 6, 1'b0);
    run_seg(3'b110, 4, 8, 1'b0);
    run_seg(3'b010, 5, 8, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    // YELLOW stalls for 10 cycles
    run_seg(3'b001, 1, 10, 1'b0);
    run_seg(3'b101, 2, 8, 1'b0);
    run_seg(3'b100, 3, 8, 1'b0);
    run_seg(3'b110, 4, 8, 1'b0);
    run_seg(3'b010, 5, 8, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    // YELLOW held only 6 cycles
    run_seg(3'b001, 1, 6, 1'b0);
    run_seg(3'b101, 2, 8, 1'b0);
    run_seg(3'b100, 3, 8, 1'b0);
    // dark while tracking
    run_seg(3'b111, 7, 4, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    run_seg(3'b001, 1, 8, 1'b0);
    // seq error coinciding with clear_err, then a lone clear_err
    run_seg(3'b100, 3, 8, 1'b1);
    run_seg(3'b110, 4, 8, 1'b1);
    run_seg(3'b010, 5, 8, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    // reset while tracking
    chk_eq("pre_rst_locked", locked, 32'd1);
    do_reset();
    run_seg(3'b101, 2, 8, 1'b0);
    run_seg(3'b100, 3, 8, 1'b0);
    run_seg(3'b110, 4, 8, 1'b0);
    // white while tracking
    run_seg(3'b000, 7, 4, 1'b0);
    run_seg(3'b010, 5, 8, 1'b0);
    run_seg(3'b011, 0, 8, 1'b0);
    run_seg(3'b001, 1, 8, 1'b0);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    chk_eq("scoreboard_drain", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
